// File: rtl/seq_counter_param.sv
// seq_counter_param
//   Parametrised sequence-position counter for the Genius game core. Tracks
//   the current step of the generated colour sequence against a target length
//   supplied by the game FSM, with IDLE/RUN/DONE start/ack handshaking.
//
// Parameters
//   WIDTH : bit width of count, target and load value
//   MAX   : highest count value before wrap (<= 2^WIDTH-1)
//
// Ports
//   clk    in   system clock, rising edge
//   R      in   synchronous active-high reset
//   start  in   pulse: clear count, enter RUN
//   E      in   step enable (RUN only)
//   dir    in   0 = up, 1 = down
//   data   in   target value; terminal when the stepped count equals it
//   ack    in   pulse: acknowledge DONE, return to IDLE
//   ld     in   (SEQCNT_LOAD_EN only) load ld_val in RUN
//   ld_val in   (SEQCNT_LOAD_EN only) value to load
//   SEQ    out  current count (registered)
//   tc     out  one-cycle terminal-count pulse
//   done   out  high in DONE
//   busy   out  high in RUN
//   ovf    out  sticky wrap flag, cleared by start or R
//
// Optional feature macro: SEQCNT_LOAD_EN (adds ld / ld_val).

module seq_counter_param #(
   parameter int WIDTH = 4,
   parameter int MAX   = 15
) (
   input  logic             clk,
   input  logic             R,
   input  logic             start,
   input  logic             E,
   input  logic             dir,
   input  logic [WIDTH-1:0] data,
   input  logic             ack,
`ifdef SEQCNT_LOAD_EN
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
`endif
   output logic [WIDTH-1:0] SEQ,
   output logic             tc,
   output logic             done,
   output logic             busy,
   output logic             ovf
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   state_t           state, state_n;
   logic [WIDTH-1:0] seq_n, step;
   logic             tc_n, ovf_n, wrap;

   // Candidate next count for an E step. Up-count uses >= so a value above
   // MAX (only reachable by a load) still folds back to 0.
   always_comb begin
      wrap = 1'b0;
      step = SEQ;
      if (!dir) begin
         wrap = (SEQ >= MAX_V);
         step = wrap ? '0 : SEQ + WIDTH'(1);
      end else begin
         wrap = (SEQ == '0);
         step = wrap ? MAX_V : SEQ - WIDTH'(1);
      end
   end

   always_comb begin
      state_n = state;
      seq_n   = SEQ;
      ovf_n   = ovf;
      tc_n    = 1'b0;
      if (start) begin
         // restart from any state; no step taken this cycle
         state_n = S_RUN;
         seq_n   = '0;
         ovf_n   = 1'b0;
      end else begin
         unique case (state)
            S_IDLE: ;
            S_RUN: begin
`ifdef SEQCNT_LOAD_EN
               if (ld) seq_n = ld_val;
               else
`endif
               if (E) begin
                  seq_n = step;
                  if (wrap) ovf_n = 1'b1;
                  // terminal compare uses the stepped value, so DONE and tc
                  // appear on the same edge as the final count
                  if (step == data) begin
                     tc_n    = 1'b1;
                     state_n = S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (ack) begin
                  state_n = S_IDLE;
                  seq_n   = '0;
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (R) begin
         state <= S_IDLE;
         SEQ   <= '0;
         tc    <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_n;
         SEQ   <= seq_n;
         tc    <= tc_n;
         ovf   <= ovf_n;
      end
   end

   // decoded straight from the state register, so these stay registered
   assign done = (state == S_DONE);
   assign busy = (state == S_RUN);

endmodule

// File: doc/seq_counter_param.md
Name: seq_counter_param

Overview:
Parametrised sequence-position counter for the Genius game core; successor to the fixed 4-bit FPGA sequence counter.
- Tracks the current step of the FPGA-generated colour sequence against a target length supplied by the game FSM.
- Width, wrap limit and direction are configurable. An explicit IDLE/RUN/DONE state machine gives start/ack handshaking with the controller.
- Sits between the game-control FSM and the sequence ROM/LFSR address input.

Parameters:
WIDTH, 4, bit width of count, target and load value
MAX, 15, highest count value before wrap (must be <= 2^WIDTH-1)

Ports:
clk  in  1  system clock; all logic on rising edge
R  in  1  reset, synchronous, active-high
start  in  1  pulse: clear count to 0 and enter RUN
E  in  1  step enable; advances count by one in RUN
dir  in  1  0 = count up, 1 = count down
data  in  WIDTH  target value; terminal when count reaches it
ack  in  1  pulse: controller acknowledges DONE, return to IDLE
SEQ  out  WIDTH  current count (registered)
tc  out  1  one-cycle pulse on terminal count
done  out  1  high while in DONE
busy  out  1  high while in RUN
ovf  out  1  sticky wrap flag, cleared by start or R

Behaviour:
- Single clock domain. Reset is synchronous and active-high; the clock and reset ports are clk and R.
- Reset: state=IDLE, SEQ=0, tc=0, done=0, busy=0, ovf=0. R overrides all other inputs in the same cycle, including mid-RUN.
- IDLE: E and ack are ignored; SEQ holds.
  - start -> RUN, SEQ=0, ovf=0.
- RUN: busy=1.
  - E=1: next = SEQ+1 (dir=0) or SEQ-1 (dir=1).
    - Up: SEQ==MAX wraps to 0.
    - Down: SEQ==0 wraps to MAX.
    - Any wrap sets ovf=1.
  - SEQ <= next.
  - If next==data (data sampled that cycle): tc=1 for exactly one cycle and state -> DONE on the same edge.
  - E=0: SEQ holds, tc=0.
- DONE: done=1, busy=0. SEQ holds the terminal value; E is ignored.
  - ack -> IDLE, SEQ=0.
- Latency: SEQ, tc, done and busy are all registered. tc and done rise on the edge after the E cycle that reached data.
- Priority: R > start > ack > E.
  - start in any state restarts: SEQ=0, ovf=0, state=RUN, no step taken that cycle, tc=0.
  - ack outside DONE is ignored.
- Boundary conditions:
  - data==0 with dir=0: terminal is reached only after wrapping (MAX+1 steps), and ovf=1.
  - data > MAX: never terminal; counter wraps indefinitely.
  - dir and data may change during RUN; the new values apply from the next E step.
- tc never stays high for two consecutive cycles.

Optional Feature:
Macro SEQCNT_LOAD_EN.
- Defined: adds inputs ld (1 bit) and ld_val (WIDTH bits).
  - ld in RUN: SEQ <= ld_val; no terminal check on that load; ovf unchanged.
  - Priority: start > ld > E.
  - ld in IDLE or DONE is ignored.
- Undefined: ports absent; behaviour as above.

Test Plan:
- R=1 for 1 cycle mid-RUN at SEQ=5 -> next cycle SEQ=0, busy=0, done=0, ovf=0, state IDLE.
- WIDTH=4, data=3, dir=0, start then E held high -> SEQ 1,2,3 on successive cycles; tc high exactly one cycle with SEQ=3; done=1; further E leaves SEQ=3; ack -> SEQ=0, done=0.
- data=0, dir=0, MAX=15, E continuous -> SEQ wraps 15->0, ovf=1, tc pulse on the 16th step.
- dir=1, data=13, MAX=15 from start -> SEQ 15,14,13, ovf=1 after the first step, tc on the third step.
- start and E asserted together in RUN at SEQ=7 -> SEQ=0, no step, tc=0; E alone next cycle -> SEQ=1.
- With SEQCNT_LOAD_EN: in RUN, ld=1, ld_val=9, data=10 -> SEQ=9, no tc; then E -> SEQ=10, tc=1, done=1.
